// File: rtl/execute_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : execute_forward_unit
//  Purpose  : Operand forwarding and load-use hazard control for the execute
//             stage. A shift-register scoreboard records the destination
//             writes of the last FWD_DEPTH instructions that left execute.
//             Entry 0 is the memory stage, and deeper entries are later
//             stages. For each source operand the unit selects the youngest
//             matching producer. It stalls when that producer is a load
//             whose data is not yet available.
//  Ports    :
//    clk, rst_n           clock, synchronous active-low reset
//    hold_in              global freeze; the scoreboard does not shift
//    flush                squash the instruction now in execute
//    issue_*              destination info of the instruction in execute
//    src_valid/src_addr   per-operand read enables and packed addresses
//    fwd_sel              per-operand select: 0 = regfile, k+1 = entry k
//    stall_out            hold execute and insert a bubble
//    stall_cycles         saturating count of stall cycles
//  Revision : 1.0  initial release
// ============================================================================
module execute_forward_unit #(
  parameter int REG_AW    = 4,
  parameter int NUM_SRC   = 3,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int PC_ADDR   = 15
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        hold_in,
  input  logic                                        flush,
  input  logic                                        issue_valid,
  input  logic                                        issue_wr_en,
  input  logic [REG_AW-1:0]                           issue_wr_addr,
  input  logic                                        issue_wr2_en,
  input  logic [REG_AW-1:0]                           issue_wr2_addr,
  input  logic                                        issue_is_load,
  input  logic [NUM_SRC-1:0]                          src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                   src_addr,
  output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]      fwd_sel,
  output logic                                        stall_out,
  output logic [15:0]                                 stall_cycles
);

  localparam int                c_sel_w = $clog2(FWD_DEPTH + 1);
  localparam logic [REG_AW-1:0] c_pc    = REG_AW'(PC_ADDR);

  // Scoreboard, one bit/field per downstream stage
  logic [FWD_DEPTH-1:0]             r_valid;
  logic [FWD_DEPTH-1:0]             r_wr_en;
  logic [FWD_DEPTH-1:0]             r_wr2_en;
  logic [FWD_DEPTH-1:0]             r_is_load;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] r_wr_addr;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] r_wr2_addr;

  logic        r_pending_flush;
  logic [15:0] r_stall_cycles;

  logic [NUM_SRC-1:0] w_src_stall;
  logic               w_accept;

  // Per-operand lookup
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0]  w_addr;
      logic [c_sel_w-1:0] w_sel;
      logic               w_ld_hit;

      assign w_addr = src_addr[gi*REG_AW +: REG_AW];

      always_comb begin
        w_sel    = '0;
        w_ld_hit = 1'b0;
        if (src_valid[gi] && (w_addr != c_pc)) begin
          // Scan oldest to youngest so the youngest match is the last writer.
          // The load check follows the primary-destination path only; a
          // base-register writeback comes from the ALU and is never late.
          for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] &&
                ((r_wr_en[k]  && (r_wr_addr[k]  == w_addr)) ||
                 (r_wr2_en[k] && (r_wr2_addr[k] == w_addr)))) begin
              w_sel    = c_sel_w'(k + 1);
              w_ld_hit = r_is_load[k] && r_wr_en[k] &&
                         (r_wr_addr[k] == w_addr) && (k < LOAD_LAT);
            end
          end
        end
      end

      assign fwd_sel[gi*c_sel_w +: c_sel_w] = w_sel;
      assign w_src_stall[gi]                = w_ld_hit;
    end
  endgenerate

  // A bubble or a squashed instruction has no consumers to protect
  assign stall_out = issue_valid & ~flush & (|w_src_stall);

  // A flush seen during a hold squashes the instruction on the next advance
  assign w_accept = issue_valid & ~stall_out & ~flush & ~r_pending_flush;

  // Control state: entry valid bits, deferred flush, stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_pending_flush <= 1'b0;
      r_stall_cycles  <= '0;
    end else if (!hold_in) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        r_valid[k] <= r_valid[k-1];
      end
      r_valid[0]      <= w_accept;
      r_pending_flush <= 1'b0;
      if (stall_out && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end else if (flush) begin
      r_pending_flush <= 1'b1;
    end
  end

  // Payload fields are only meaningful when the matching valid bit is set
  always_ff @(posedge clk) begin
    if (!hold_in) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        r_wr_en[k]    <= r_wr_en[k-1];
        r_wr_addr[k]  <= r_wr_addr[k-1];
        r_wr2_en[k]   <= r_wr2_en[k-1];
        r_wr2_addr[k] <= r_wr2_addr[k-1];
        r_is_load[k]  <= r_is_load[k-1];
      end
      r_wr_en[0]    <= issue_wr_en;
      r_wr_addr[0]  <= issue_wr_addr;
      r_wr2_en[0]   <= issue_wr2_en;
      r_wr2_addr[0] <= issue_wr2_addr;
      r_is_load[0]  <= issue_is_load;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_execute_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_forward_unit
//  Purpose  : Self-checking bench for execute_forward_unit. Two instances
//             share one stimulus stream: the default configuration, and a
//             deeper one (NUM_SRC=2, FWD_DEPTH=3, LOAD_LAT=2). A behavioural
//             history model predicts every output on each cycle. Directed
//             scenarios also pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_execute_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hold_in, flush, issue_valid, issue_wr_en, issue_wr2_en, issue_is_load;
  logic [3:0]  issue_wr_addr, issue_wr2_addr;
  logic [2:0]  src_valid;
  logic [11:0] src_addr;
  logic [5:0]  fwd0;
  logic [3:0]  fwd1;
  logic        stall0, stall1;
  logic [15:0] cnt0, cnt1;

  execute_forward_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .hold_in(hold_in), .flush(flush),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
    .issue_wr2_en(issue_wr2_en), .issue_wr2_addr(issue_wr2_addr), .issue_is_load(issue_is_load),
    .src_valid(src_valid), .src_addr(src_addr),
    .fwd_sel(fwd0), .stall_out(stall0), .stall_cycles(cnt0)
  );

  execute_forward_unit #(
    .REG_AW(4), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2), .PC_ADDR(15)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hold_in(hold_in), .flush(flush),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
    .issue_wr2_en(issue_wr2_en), .issue_wr2_addr(issue_wr2_addr), .issue_is_load(issue_is_load),
    .src_valid(src_valid[1:0]), .src_addr(src_addr[7:0]),
    .fwd_sel(fwd1), .stall_out(stall1), .stall_cycles(cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[c][k] is what left execute k+1 advances ago, for configuration c
  typedef struct {
    bit v; bit we; bit we2; bit ld; int wa; int wa2;
  } ent_t;

  ent_t hist [2][3];
  int   m_pend [2];
  int   m_cnt  [2];

  function automatic int depth_of(int c); return (c == 0) ? 2 : 3; endfunction
  function automatic int lat_of(int c);   return (c == 0) ? 1 : 2; endfunction
  function automatic int nsrc_of(int c);  return (c == 0) ? 3 : 2; endfunction

  function automatic int exp_sel(int c, int i);
    int a, res;
    bit found;
    a = int'(src_addr[i*4 +: 4]);
    res = 0;
    found = 1'b0;
    if (src_valid[i] && a != 15) begin
      for (int k = 0; k < depth_of(c); k++) begin
        if (!found && hist[c][k].v &&
            ((hist[c][k].we && hist[c][k].wa == a) || (hist[c][k].we2 && hist[c][k].wa2 == a))) begin
          found = 1'b1;
          res = k + 1;
        end
      end
    end
    return res;
  endfunction

  function automatic bit exp_stall(int c);
    bit r;
    int s, a;
    r = 1'b0;
    if (issue_valid && !flush) begin
      for (int i = 0; i < nsrc_of(c); i++) begin
        s = exp_sel(c, i);
        a = int'(src_addr[i*4 +: 4]);
        if (s > 0) begin
          if (hist[c][s-1].ld && hist[c][s-1].we && hist[c][s-1].wa == a && (s - 1) < lat_of(c))
            r = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Model state update on each rising edge (inputs change only #1 later)
  initial begin : p_model
    ent_t ne;
    bit   st;
    forever begin
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!rst_n) begin
          for (int k = 0; k < 3; k++) hist[c][k].v = 1'b0;
          m_pend[c] = 0;
          m_cnt[c]  = 0;
        end else if (!hold_in) begin
          st = exp_stall(c);
          if (st && m_cnt[c] < 65535) m_cnt[c]++;
          for (int k = depth_of(c) - 1; k >= 1; k--) hist[c][k] = hist[c][k-1];
          ne.v   = issue_valid && !st && !flush && (m_pend[c] == 0);
          ne.we  = issue_wr_en;
          ne.wa  = int'(issue_wr_addr);
          ne.we2 = issue_wr2_en;
          ne.wa2 = int'(issue_wr2_addr);
          ne.ld  = issue_is_load;
          hist[c][0] = ne;
          m_pend[c]  = 0;
        end else if (flush) begin
          m_pend[c] = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin : p_compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++)
          chk($sformatf("dut0 fwd_sel[%0d]", i), int'(fwd0[i*2 +: 2]), exp_sel(0, i));
        for (int i = 0; i < 2; i++)
          chk($sformatf("dut1 fwd_sel[%0d]", i), int'(fwd1[i*2 +: 2]), exp_sel(1, i));
        chk("dut0 stall_out", int'(stall0), int'(exp_stall(0)));
        chk("dut1 stall_out", int'(stall1), int'(exp_stall(1)));
        chk("dut0 stall_cycles", int'(cnt0), m_cnt[0]);
        chk("dut1 stall_cycles", int'(cnt1), m_cnt[1]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int f0(int i); return int'(fwd0[i*2 +: 2]); endfunction
  function automatic int f1(int i); return int'(fwd1[i*2 +: 2]); endfunction

  task automatic set_nop();
    hold_in = 0; flush = 0; issue_valid = 0; issue_wr_en = 0; issue_wr_addr = 0;
    issue_wr2_en = 0; issue_wr2_addr = 0; issue_is_load = 0; src_valid = 0; src_addr = 0;
  endtask

  task automatic issue(input int wa, input bit we, input int wa2, input bit we2, input bit ld);
    issue_valid = 1; issue_wr_addr = 4'(wa); issue_wr_en = we;
    issue_wr2_addr = 4'(wa2); issue_wr2_en = we2; issue_is_load = ld;
  endtask

  task automatic src(input int i, input int a);
    src_valid[i] = 1'b1;
    src_addr[i*4 +: 4] = 4'(a);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] ra();
    return ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(2, 7));
  endfunction

  task automatic rand_inputs();
    hold_in        = ($urandom_range(0, 99) < 12);
    flush          = ($urandom_range(0, 99) < 8);
    issue_valid    = ($urandom_range(0, 99) < 75);
    issue_wr_en    = ($urandom_range(0, 99) < 80);
    issue_wr_addr  = ra();
    issue_wr2_en   = ($urandom_range(0, 99) < 25);
    issue_wr2_addr = ra();
    issue_is_load  = ($urandom_range(0, 99) < 40);
    src_valid      = 3'($urandom_range(0, 7));
    src_addr       = {ra(), ra(), ra()};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 0;
    set_nop();
    step();
    chk_en = 1'b1;

    // Reset with random inputs
    repeat (2) begin
      rand_inputs();
      @(negedge clk);
      chk("reset fwd0 op0", f0(0), 0);
      chk("reset fwd0 op2", f0(2), 0);
      chk("reset stall0", int'(stall0), 0);
      chk("reset cnt0", int'(cnt0), 0);
      chk("reset cnt1", int'(cnt1), 0);
      step();
    end
    rst_n = 1;
    set_nop(); src(0, 3); src(1, 5); src(2, 7);
    @(negedge clk);
    chk("post-reset fwd0 op1", f0(1), 0);
    step();

    // Back-to-back ALU forwarding
    set_nop(); issue(3, 1, 0, 0, 0);
    step();
    set_nop(); issue(0, 0, 0, 0, 0); src(0, 3);
    @(negedge clk);
    chk("alu e0 dut0", f0(0), 1);
    chk("alu e0 dut1", f1(0), 1);
    step();
    set_nop(); src(0, 3);
    @(negedge clk);
    chk("alu e1 dut0", f0(0), 2);
    chk("alu e1 dut1", f1(0), 2);
    step();
    @(negedge clk);
    chk("alu aged-out dut0", f0(0), 0);
    chk("alu e2 dut1", f1(0), 3);
    step();

    // Youngest wins; PC never forwards
    set_nop(); issue(5, 1, 15, 1, 0);
    step();
    set_nop(); issue(5, 1, 0, 0, 0);
    step();
    set_nop(); src(1, 5);
    @(negedge clk);
    chk("youngest dut0", f0(1), 1);
    chk("youngest dut1", f1(1), 1);
    #1;
    src_addr[7:4] = 4'd15;
    #1;
    chk("pc no-fwd dut0", f0(1), 0);
    chk("pc no-fwd dut1", f1(1), 0);
    step();

    // Load-use
    rst_n = 0; set_nop();
    step();
    rst_n = 1;
    issue(4, 1, 0, 0, 1);
    step();
    set_nop(); issue(7, 1, 0, 0, 0); src(1, 4);
    @(negedge clk);
    chk("ldu stall0 c1", int'(stall0), 1);
    chk("ldu stall1 c1", int'(stall1), 1);
    chk("ldu fwd0 c1", f0(1), 1);
    step();
    @(negedge clk);
    chk("ldu stall0 c2", int'(stall0), 0);
    chk("ldu fwd0 c2", f0(1), 2);
    chk("ldu cnt0", int'(cnt0), 1);
    chk("ldu stall1 c2", int'(stall1), 1);
    chk("ldu fwd1 c2", f1(1), 2);
    step();
    @(negedge clk);
    chk("ldu stall1 c3", int'(stall1), 0);
    chk("ldu fwd1 c3", f1(1), 3);
    chk("ldu cnt1", int'(cnt1), 2);
    chk("ldu cnt0 final", int'(cnt0), 1);
    step();

    // Load whose base writeback is read: ALU path, no stall
    set_nop(); issue(9, 1, 6, 1, 1);
    step();
    set_nop(); issue(0, 0, 0, 0, 0); src(0, 6);
    @(negedge clk);
    chk("wr2 fwd0", f0(0), 1);
    chk("wr2 stall0", int'(stall0), 0);
    chk("wr2 stall1", int'(stall1), 0);
    step();

    // Flush under hold
    set_nop(); step();
    set_nop(); step();
    set_nop(); step();
    issue(8, 1, 0, 0, 0); hold_in = 1; flush = 1;
    step();
    hold_in = 0; flush = 0;
    step();
    set_nop(); src(0, 8);
    @(negedge clk);
    chk("flush-hold fwd0", f0(0), 0);
    chk("flush-hold fwd1", f1(0), 0);
    step();

    // Randomised traffic with occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    rst_n = 1; set_nop();
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_forward_unit.md
Name: execute_forward_unit

Overview:
- Parametrised forwarding and hazard controller for the execute stage.
- Tracks destination-register writes of the last FWD_DEPTH instructions that left execute in a shift-register scoreboard. Index 0 is the memory stage; deeper indices are later stages.
- Each cycle, for every source operand of the instruction now in execute, produces a bypass select.
- Raises a load-use stall when a load result is not yet available.

Parameters:
- REG_AW, 4: register address width.
- NUM_SRC, 3: number of source operands checked (Rn, Rm, Rs order).
- FWD_DEPTH, 2: number of downstream stages tracked, ≥1.
- LOAD_LAT, 1: a load result is unavailable while its entry index < LOAD_LAT; range 0..FWD_DEPTH.
- PC_ADDR, 15: register address that never forwards.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- hold_in  in  1  global pipeline freeze; the scoreboard does not shift.
- flush  in  1  squash the instruction currently in execute.
- issue_valid  in  1  execute holds a real instruction (0 = NOP/bubble).
- issue_wr_en  in  1  instruction writes issue_wr_addr.
- issue_wr_addr  in  REG_AW  primary destination (Rd).
- issue_wr2_en  in  1  instruction writes back its base register.
- issue_wr2_addr  in  REG_AW  writeback base (Rn).
- issue_is_load  in  1  primary destination is loaded from memory.
- src_valid  in  NUM_SRC  operand i is read by this instruction.
- src_addr  in  NUM_SRC*REG_AW  operand i address, operand i at bits [i*REG_AW +: REG_AW].
- fwd_sel  out  NUM_SRC*SELW  per-operand select; SELW = $clog2(FWD_DEPTH+1). 0 = register file, k+1 = result of entry k.
- stall_out  out  1  hold execute and insert a bubble.
- stall_cycles  out  16  saturating count of stall cycles.

Behaviour:
- Scoreboard entry fields: valid, wr_en, wr_addr, wr2_en, wr2_addr, is_load.
- Reset (rst_n=0 at posedge):
  - all entries invalid;
  - stall_cycles=0;
  - pending_flush=0.
  - Consequently fwd_sel=0 and stall_out=0 while in reset.
- Advance condition is hold_in=0. On advance:
  - entry[k] <= entry[k-1] for k≥1;
  - entry[0] <= issue fields if issue_valid & ~stall_out & ~flush & ~pending_flush, otherwise a bubble (valid=0);
  - entry[FWD_DEPTH-1] is discarded.
- If hold_in=1, all entries keep their values.
- Flush during hold: if flush=1 and hold_in=1, set pending_flush. The next advance inserts a bubble and clears pending_flush. A flush on a non-hold cycle takes effect immediately; pending_flush stays 0.
- Match rule:
  - entry k matches address a when valid & ((wr_en & wr_addr==a) | (wr2_en & wr2_addr==a)) and a != PC_ADDR.
  - Entries with valid=0 never match.
- fwd_sel (combinational from registered entries and current src inputs):
  - For operand i with src_valid[i]=1: the smallest k that matches (youngest wins) gives fwd_sel_i = k+1. No match gives 0.
  - src_valid[i]=0 gives 0.
- stall_out (combinational):
  - Asserted when some operand i's selected entry k has is_load=1, k<LOAD_LAT, and the match came via wr_addr.
  - If the match came only via wr2_addr (base writeback from the ALU), there is no stall.
  - If both wr_addr and wr2_addr of the same entry match, the wr_addr path decides.
  - stall_out is forced to 0 when issue_valid=0 or flush=1.
  - LOAD_LAT=0 means stall_out is never asserted.
- During stall: execute keeps its instruction; the bubble shifts in; forwarding re-evaluates each cycle. With LOAD_LAT=1 the stall lasts exactly one cycle.
- stall_cycles increments on each posedge where stall_out=1 & hold_in=0, and saturates at 16'hFFFF.
- Latency: an instruction issued at edge N is visible as entry 0 from cycle N+1 and as entry k from cycle N+1+k (no holds).
- Reset mid-operation discards all entries; there is no partial state.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> fwd_sel=0, stall_out=0, stall_cycles=0; all entries invalid after release.
- Back-to-back ALU (defaults): issue ADD wr_addr=3; next cycle src_addr[0]=3 -> fwd_sel_0=1. Cycle after, with a NOP in between -> fwd_sel_0=2. One more cycle -> fwd_sel_0=0.
- Youngest wins: writes to R5 at entries 0 and 1, src_addr[1]=5 -> fwd_sel_1=1. Same case with src_addr=15 (PC) -> fwd_sel_1=0.
- Load-use: LDR wr_addr=4 is_load=1, then instruction reading R4 as Rm -> stall_out=1 for exactly 1 cycle, stall_cycles=1, then fwd_sel_1=2. A load with wr2_en, wr2_addr=6 read at entry 0 -> fwd_sel=1, stall_out=0.
- Flush under hold: hold_in=1 with flush=1 pulsed for 1 cycle, then hold_in=0 -> entry 0 is a bubble, and the next dependent read gets fwd_sel=0 for that register.
- Parametric: FWD_DEPTH=3, LOAD_LAT=2 -> SELW=2; a load-use stalls 2 cycles, then fwd_sel=3. NUM_SRC=2 compiles and checks operands 0..1 only.
